rr_priority_arbiter: RTL
========================

// Module: rr_priority_arbiter
// PURPOSE
//  Round-robin arbiter sharing one resource between 2**NUM_BITS requesters.
//  Winner selection is a rotating 2^n-to-n priority encoder: the lowest set
//  request index at or after the pointer wins, wrapping at 2**NUM_BITS-1.
//  Grant is registered and held until the owner releases. Sits in front of
//  any shared datapath (bus, ALU, memory port) that has multiple clients.
// PARAMETERS
//  NUM_BITS  3   index width; number of requesters = 2**NUM_BITS
//  MAX_HOLD  15  max BUSY cycles per grant (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk           input   1            clock; all state changes on posedge
//  reset         input   1            async, active-high; clears all state
//  req           input   2**NUM_BITS  request vector, level, one bit/client
//  done          input   1            owner releases the resource this cycle
//  grant         output  2**NUM_BITS  one-hot grant, registered
//  grantIdx      output  NUM_BITS     binary index of owner, registered
//  valid         output  1            grant is active (grant != 0)
//  timeoutPulse  output  1            1-cycle flag: grant forcibly revoked
// BEHAVIOUR
//  Reset: grant=0, grantIdx=0, valid=0, timeoutPulse=0, ptr=0, state=IDLE.
//  Reset mid-operation clears grant immediately; no release is recorded.
//  States: IDLE, BUSY.
//  IDLE: if |req, go to BUSY; next cycle grant=onehot(w), grantIdx=w,
//   valid=1, w = pick(req, ptr). Latency req->grant = 1 cycle. done ignored.
//  BUSY: release = done | ~req[grantIdx] | forced timeout.
//   No release: grant, grantIdx and valid hold; req changes on other bits
//   have no effect.
//   On release: ptr <= (grantIdx+1) mod 2**NUM_BITS. In the same cycle,
//   pick from req with the owner bit masked, starting at the new ptr.
//    Other request pending: stay BUSY; new grant next cycle (back-to-back,
//    no idle cycle).
//    No other request: go to IDLE; grant=0, valid=0 next cycle. grantIdx
//    holds its last value.
//  Wrap: owner 2**NUM_BITS-1 releases -> ptr = 0.
//  Simultaneous done plus a new request from another client: the new
//  request competes in the same arbitration.
//  valid == |grant at all times; grant is never multi-hot.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: holdCnt counts BUSY cycles of the current owner,
//   cleared on each new grant. When holdCnt == MAX_HOLD-1 and there is no
//   release, a forced release occurs with the rules above. timeoutPulse=1
//   for the cycle the new grant or IDLE takes effect.
//  ARB_TIMEOUT_EN undefined: no counter; timeoutPulse tied 0; the owner may
//   hold indefinitely.
// STRUCTURE
//  arb_pkg: state enum typedef (IDLE, BUSY); default NUM_BITS constant.
//  Sub-module rr_pick: combinational rotating priority encoder.
//   In: req, ptr, mask. Out: winner index, any.
//   Implementation: rotate right by ptr, lowest-set-bit encode, add ptr
//   back modulo 2**NUM_BITS.
//  Top module: FSM, ptr register, output registers, optional holdCnt.
// TESTING (NUM_BITS=3)
//  1 reset=1 with req=8'hFF -> grant=0, valid=0, grantIdx=0 while reset is
//    high; after release, first grant is idx 0.
//  2 req=8'b0000_0001 at cycle 0 -> cycle 1 grant=8'b0000_0001, idx=0;
//    done=1 for one cycle -> next cycle grant=0, valid=0.
//  3 req=8'b1000_0101 held, done pulsed each grant -> grantIdx sequence
//    0,2,7,0 with no idle cycles between grants.
//  4 owner idx=2, req[2] dropped without done, req[5]=1 -> next cycle
//    grantIdx=5.
//  5 BUSY with idx=5, reset asserted between clock edges -> grant=0
//    immediately; after release with req=8'hFF -> idx 0.
//  6 ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'b0000_0011, done=0 -> idx 0 for 4
//    cycles, then idx 1 with timeoutPulse=1 for one cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter slice.
// Holds the FSM state encoding and the default index width.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int NUM_BITS_DEF = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: lowest unmasked request at or after ptr wins.
// Zero latency, no flow control; 'any' is low when no unmasked request exists.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEF
) (
  input  logic [2**NUM_BITS-1:0] req,
  input  logic [NUM_BITS-1:0]    ptr,
  input  logic [2**NUM_BITS-1:0] mask,
  output logic [NUM_BITS-1:0]    winner,
  output logic                   any
);

  localparam int N = 2**NUM_BITS;

  logic [N-1:0]        eff;
  logic [N-1:0]        rot;
  logic [NUM_BITS-1:0] lsb;

  always_comb begin
    eff = req & ~mask;
    // Rotating right by ptr puts the highest-priority requester at bit 0.
    rot = N'({eff, eff} >> ptr);
    any = |eff;
    lsb = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) lsb = NUM_BITS'(i);
    end
    winner = lsb + ptr;
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter, registered one-hot grant held until release; req->grant 1 cycle, back-to-back handoff.
// Optional forced release after MAX_HOLD busy cycles when ARB_TIMEOUT_EN is defined.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEF,
  parameter int MAX_HOLD = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2**NUM_BITS-1:0] req,
  input  logic                   done,
  output logic [2**NUM_BITS-1:0] grant,
  output logic [NUM_BITS-1:0]    grantIdx,
  output logic                   valid,
  output logic                   timeoutPulse
);

  localparam int N = 2**NUM_BITS;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] ptr_q, ptr_d;
  logic [N-1:0]        grant_q, grant_d;
  logic [NUM_BITS-1:0] idx_q, idx_d;
  logic                valid_q, valid_d;

  logic [NUM_BITS-1:0] pick_ptr;
  logic [N-1:0]        pick_mask;
  logic [NUM_BITS-1:0] win;
  logic                win_any;
  logic                natural_rel;
  logic                forced;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HW-1:0] hold_q, hold_d;
  logic          tpulse_q, tpulse_d;

  assign forced       = (hold_q == HW'(MAX_HOLD - 1)) & ~natural_rel;
  assign timeoutPulse = tpulse_q;
`else
  localparam int unused_max_hold = MAX_HOLD;

  assign forced       = 1'b0;
  assign timeoutPulse = 1'b0;
`endif

  assign natural_rel = done | ~req[idx_q];

  // While busy, the search starts after the owner and excludes it.
  always_comb begin
    pick_ptr  = ptr_q;
    pick_mask = '0;
    if (state_q == BUSY) begin
      pick_ptr  = idx_q + NUM_BITS'(1);
      pick_mask = N'(1) << idx_q;
    end
  end

  rr_pick #(.NUM_BITS(NUM_BITS)) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .mask   (pick_mask),
    .winner (win),
    .any    (win_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
`ifdef ARB_TIMEOUT_EN
    hold_d   = hold_q;
    tpulse_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = BUSY;
          grant_d = N'(1) << win;
          idx_d   = win;
          valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      BUSY: begin
        if (natural_rel | forced) begin
          ptr_d = idx_q + NUM_BITS'(1);
`ifdef ARB_TIMEOUT_EN
          tpulse_d = forced;
          hold_d   = '0;
`endif
          if (win_any) begin
            grant_d = N'(1) << win;
            idx_d   = win;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_d = hold_q + HW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q   <= '0;
      tpulse_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
`ifdef ARB_TIMEOUT_EN
      hold_q   <= hold_d;
      tpulse_q <= tpulse_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign grantIdx = idx_q;
  assign valid    = valid_q;

endmodule
